// File: rtl/cpu_fetch.sv
// Instruction fetch stage for the 2A03 core: reads opcode/operand bytes over a
// zero-wait-state bus and hands one complete instruction to decode per handshake.

package cpu_types;
    typedef logic [7:0] opcode_t;
endpackage

module cpu_fetch #(
    parameter logic [15:0] RST_PC = 16'hC000
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_ren,
    output logic [15:0]         mem_addr,
    input  logic [7:0]          mem_rdata,
    output logic                ins_valid,
    input  logic                ins_ready,
    output cpu_types::opcode_t  ins_opcode,
    output logic [7:0]          ins_op1,
    output logic [7:0]          ins_op2,
    output logic [1:0]          ins_len,
    output logic [15:0]         ins_pc,
    input  logic                redir_en,
    input  logic [15:0]         redir_pc
);

    typedef enum logic [2:0] {
        ISSUE,
        RECV_OPC,
        RECV_OP1,
        RECV_OP2,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        fpc_q, fpc_d;
    cpu_types::opcode_t opcode_q, opcode_d;
    logic [7:0]         op1_q, op1_d;
    logic [7:0]         op2_q, op2_d;
    logic [1:0]         len_q, len_d;
    logic [15:0]        pc_q, pc_d;
    logic               rd_en;
    logic [1:0]         rdata_len;

    // Instruction length from the cc/bbb fields of the 6502 opcode map.
    function automatic logic [1:0] op_len(input cpu_types::opcode_t op);
        logic [2:0] bbb;
        bbb = op[4:2];
        op_len = 2'd1;
        case (op[1:0])
            2'b01: op_len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd3 : 2'd2;
            2'b10: begin
                case (bbb)
                    3'b000, 3'b001, 3'b101: op_len = 2'd2;
                    3'b011, 3'b111:         op_len = 2'd3;
                    default:                op_len = 2'd1;
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'b001, 3'b100, 3'b101: op_len = 2'd2;
                    3'b011, 3'b111:         op_len = 2'd3;
                    3'b010, 3'b110:         op_len = 2'd1;
                    default: begin
                        case (op[7:5])
                            3'b000:         op_len = 2'd2;
                            3'b001:         op_len = 2'd3;
                            3'b010, 3'b011: op_len = 2'd1;
                            default:        op_len = 2'd2;
                        endcase
                    end
                endcase
            end
            default: op_len = 2'd1;
        endcase
    endfunction

    assign rdata_len = op_len(mem_rdata);

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        len_d    = len_q;
        pc_d     = pc_q;
        rd_en    = 1'b0;
        if (redir_en) begin
            // Redirect beats any pending read; a completing handshake still
            // counts, the consumer has already taken the held instruction.
            fpc_d   = redir_pc;
            state_d = ISSUE;
        end else begin
            case (state_q)
                ISSUE: begin
                    rd_en   = 1'b1;
                    fpc_d   = fpc_q + 16'd1;
                    pc_d    = fpc_q;
                    state_d = RECV_OPC;
                end
                RECV_OPC: begin
                    opcode_d = mem_rdata;
                    op1_d    = '0;
                    op2_d    = '0;
                    len_d    = rdata_len;
                    if (rdata_len == 2'd1) begin
                        state_d = HOLD;
                    end else begin
                        rd_en   = 1'b1;
                        fpc_d   = fpc_q + 16'd1;
                        state_d = RECV_OP1;
                    end
                end
                RECV_OP1: begin
                    op1_d = mem_rdata;
                    if (len_q == 2'd2) begin
                        state_d = HOLD;
                    end else begin
                        rd_en   = 1'b1;
                        fpc_d   = fpc_q + 16'd1;
                        state_d = RECV_OP2;
                    end
                end
                RECV_OP2: begin
                    op2_d   = mem_rdata;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (ins_ready) begin
                        rd_en   = 1'b1;
                        fpc_d   = fpc_q + 16'd1;
                        pc_d    = fpc_q;
                        state_d = RECV_OPC;
                    end
                end
                default: state_d = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ISSUE;
            fpc_q    <= RST_PC;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            len_q    <= '0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            len_q    <= len_d;
            pc_q     <= pc_d;
        end
    end

    assign mem_ren    = rd_en && !rst;
    assign mem_addr   = fpc_q;
    assign ins_valid  = (state_q == HOLD);
    assign ins_opcode = opcode_q;
    assign ins_op1    = op1_q;
    assign ins_op2    = op2_q;
    assign ins_len    = len_q;
    assign ins_pc     = pc_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch with a zero-wait-state memory model.

module tb_cpu_fetch;

    logic               clk = 1'b0;
    logic               rst;
    logic               mem_ren;
    logic [15:0]        mem_addr;
    logic [7:0]         mem_rdata = 8'h00;
    logic               ins_valid;
    logic               ins_ready;
    cpu_types::opcode_t ins_opcode;
    logic [7:0]         ins_op1;
    logic [7:0]         ins_op2;
    logic [1:0]         ins_len;
    logic [15:0]        ins_pc;
    logic               redir_en;
    logic [15:0]        redir_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] sw_op  [9] = '{8'h00, 8'h20, 8'h40, 8'h10, 8'h6C, 8'h8A, 8'h96, 8'hBE, 8'hFF};
    logic [1:0] sw_len [9] = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};

    cpu_fetch #(.RST_PC(16'hC000)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins_opcode (ins_opcode),
        .ins_op1    (ins_op1),
        .ins_op2    (ins_op2),
        .ins_len    (ins_len),
        .ins_pc     (ins_pc),
        .redir_en   (redir_en),
        .redir_pc   (redir_pc)
    );

    always #5 clk = ~clk;

    // Garbage on idle cycles so stale data use shows up.
    always @(posedge clk) mem_rdata <= mem_ren ? mem[mem_addr] : 8'h5A;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic bus(input string tag, input logic ren, input logic [15:0] addr);
        check({tag, "_ren"}, {31'd0, mem_ren}, {31'd0, ren});
        if (ren) check({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, addr});
    endtask

    task automatic check_ins(input string tag, input logic [7:0] op, input logic [7:0] o1,
                             input logic [7:0] o2, input logic [1:0] len, input logic [15:0] pc);
        check({tag, "_valid"}, {31'd0, ins_valid}, 32'd1);
        check({tag, "_opc"}, {24'd0, ins_opcode}, {24'd0, op});
        check({tag, "_op1"}, {24'd0, ins_op1}, {24'd0, o1});
        check({tag, "_op2"}, {24'd0, ins_op2}, {24'd0, o2});
        check({tag, "_len"}, {30'd0, ins_len}, {30'd0, len});
        check({tag, "_pc"}, {16'd0, ins_pc}, {16'd0, pc});
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ins_ready = 1'b0;
        redir_en  = 1'b0;
        redir_pc  = 16'h0000;
        cyc();
        settle();
        check("rst_ren", {31'd0, mem_ren}, 32'd0);
        cyc();
        settle();
        check("rst_valid", {31'd0, ins_valid}, 32'd0);
        check("rst_len", {30'd0, ins_len}, 32'd0);
        check("rst_pc", {16'd0, ins_pc}, 32'd0);
        check("rst_opc", {24'd0, ins_opcode}, 32'd0);
        check("rst_op1", {24'd0, ins_op1}, 32'd0);
        rst = 1'b0;
        settle();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;

        // Basic 2-byte fetch after reset
        mem[16'hC000] = 8'hA9;
        mem[16'hC001] = 8'h05;
        do_reset();
        bus("t1_c0", 1'b1, 16'hC000);
        check("t1_c0_valid", {31'd0, ins_valid}, 32'd0);
        cyc(); settle();
        bus("t1_c1", 1'b1, 16'hC001);
        cyc(); settle();
        bus("t1_c2", 1'b0, 16'h0000);
        check("t1_c2_valid", {31'd0, ins_valid}, 32'd0);
        cyc(); settle();
        check_ins("t1", 8'hA9, 8'h05, 8'h00, 2'd2, 16'hC000);
        bus("t1_c3", 1'b0, 16'h0000);

        // Back-to-back 1-byte stream
        for (int i = 0; i < 4; i++) mem[16'hC000 + 16'(i)] = 8'hEA;
        do_reset();
        ins_ready = 1'b1;
        settle();
        for (int k = 1; k <= 7; k++) begin
            cyc(); settle();
            check("t2_valid", {31'd0, ins_valid}, {31'd0, (k % 2 == 0)});
            if (k % 2 == 0) begin
                check("t2_pc", {16'd0, ins_pc}, {16'd0, 16'hC000 + 16'(k / 2 - 1)});
                check("t2_len", {30'd0, ins_len}, 32'd1);
                bus("t2_next", 1'b1, 16'hC000 + 16'(k / 2));
            end
        end

        // 3-byte instruction held while consumer stalls
        mem[16'hC000] = 8'h4C;
        mem[16'hC001] = 8'h34;
        mem[16'hC002] = 8'h12;
        do_reset();
        repeat (3) cyc();
        for (int h = 0; h < 5; h++) begin
            cyc(); settle();
            check_ins("t3_hold", 8'h4C, 8'h34, 8'h12, 2'd3, 16'hC000);
            bus("t3_hold", 1'b0, 16'h0000);
        end
        cyc();
        ins_ready = 1'b1;
        settle();
        bus("t3_go", 1'b1, 16'hC003);
        cyc();
        ins_ready = 1'b0;
        settle();
        check("t3_after_valid", {31'd0, ins_valid}, 32'd0);

        // Reset in the middle of an instruction
        mem[16'hC000] = 8'hAD;
        mem[16'hC001] = 8'h00;
        mem[16'hC002] = 8'h20;
        mem[16'h8000] = 8'hEA;
        do_reset();
        cyc(); cyc();
        rst = 1'b1;
        settle();
        bus("mr_rst", 1'b0, 16'h0000);
        cyc();
        rst = 1'b0;
        settle();
        bus("mr_restart", 1'b1, 16'hC000);
        check("mr_valid", {31'd0, ins_valid}, 32'd0);
        check("mr_len", {30'd0, ins_len}, 32'd0);

        // Redirect during operand fetch
        cyc(); cyc();
        redir_en = 1'b1;
        redir_pc = 16'h8000;
        settle();
        bus("t4_redir", 1'b0, 16'h0000);
        cyc();
        redir_en = 1'b0;
        settle();
        bus("t4_issue", 1'b1, 16'h8000);
        check("t4_issue_valid", {31'd0, ins_valid}, 32'd0);
        cyc(); settle();
        check("t4_opc_valid", {31'd0, ins_valid}, 32'd0);
        cyc(); settle();
        check_ins("t4", 8'hEA, 8'h00, 8'h00, 2'd1, 16'h8000);

        // PC wrap across FFFF
        mem[16'hFFFE] = 8'hAD;
        mem[16'hFFFF] = 8'h34;
        mem[16'h0000] = 8'h12;
        mem[16'h0001] = 8'hEA;
        cyc();
        redir_en = 1'b1;
        redir_pc = 16'hFFFE;
        settle();
        bus("t5_redir", 1'b0, 16'h0000);
        cyc();
        redir_en = 1'b0;
        settle();
        bus("t5_a0", 1'b1, 16'hFFFE);
        cyc(); settle();
        bus("t5_a1", 1'b1, 16'hFFFF);
        cyc(); settle();
        bus("t5_a2", 1'b1, 16'h0000);
        cyc(); settle();
        bus("t5_a3", 1'b0, 16'h0000);
        check("t5_op2_valid", {31'd0, ins_valid}, 32'd0);
        cyc(); settle();
        check_ins("t5", 8'hAD, 8'h34, 8'h12, 2'd3, 16'hFFFE);
        cyc();
        ins_ready = 1'b1;
        settle();
        bus("t5_next", 1'b1, 16'h0001);

        // Redirect coinciding with a handshake
        cyc();
        ins_ready = 1'b0;
        settle();
        check("t6_opc_valid", {31'd0, ins_valid}, 32'd0);
        cyc(); settle();
        check_ins("t6", 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0001);
        cyc();
        ins_ready = 1'b1;
        redir_en  = 1'b1;
        redir_pc  = 16'hA000;
        settle();
        bus("t6_both", 1'b0, 16'h0000);
        check("t6_both_valid", {31'd0, ins_valid}, 32'd1);
        cyc();
        ins_ready = 1'b0;
        redir_en  = 1'b0;
        settle();
        check("t6_after_valid", {31'd0, ins_valid}, 32'd0);
        bus("t6_after", 1'b1, 16'hA000);

        // Length decode sweep
        for (int i = 0; i < 9; i++) begin
            mem[16'h9000 + 16'(i * 4)]     = sw_op[i];
            mem[16'h9000 + 16'(i * 4 + 1)] = 8'h11;
            mem[16'h9000 + 16'(i * 4 + 2)] = 8'h22;
        end
        for (int i = 0; i < 9; i++) begin
            cyc();
            redir_en = 1'b1;
            redir_pc = 16'h9000 + 16'(i * 4);
            settle();
            cyc();
            redir_en = 1'b0;
            settle();
            for (int j = 0; j < 8 && !ins_valid; j++) begin
                cyc(); settle();
            end
            check_ins("sweep", sw_op[i], (sw_len[i] >= 2'd2) ? 8'h11 : 8'h00,
                      (sw_len[i] == 2'd3) ? 8'h22 : 8'h00, sw_len[i], 16'h9000 + 16'(i * 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Instruction fetch stage for the 2A03 CPU core. Reads opcode and operand bytes from the CPU bus, decodes instruction length from the opcode, and presents one complete instruction (opcode, up to two operand bytes, length, opcode PC) to the decode/execute stage over a valid/ready handshake. Accepts a PC redirect from execute for jumps, branches, interrupts and the reset vector. Sits between the CPU memory bus and the cpu DECODE state.

## Interface

Parameters:
- RST_PC, 16'hC000, fetch PC loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mem_ren  out  1  bus read strobe; combinational from state.
- mem_addr  out  16  read address; valid when mem_ren=1.
- mem_rdata  in  8  read data; valid exactly one cycle after mem_ren=1, no wait states.
- ins_valid  out  1  instruction outputs valid.
- ins_ready  in  1  consumer accepts the instruction this cycle.
- ins_opcode  out  8  opcode byte, type opcode_t from cpu_types.
- ins_op1  out  8  first operand byte; 0 if ins_len<2.
- ins_op2  out  8  second operand byte; 0 if ins_len<3.
- ins_len  out  2  instruction length in bytes, 1..3.
- ins_pc  out  16  address of the opcode byte.
- redir_en  in  1  load redir_pc and flush.
- redir_pc  in  16  new fetch PC.

## Operation

- Internal fetch PC fpc, 16 bits, increments by 1 per issued read, wraps FFFF→0000.
- States: ISSUE, RECV_OPC, RECV_OP1, RECV_OP2, HOLD.
- ISSUE: mem_ren=1, addr=fpc; fpc++; ins_pc<=fpc; →RECV_OPC.
- RECV_OPC: latch mem_rdata into ins_opcode, clear ins_op1/op2, latch ins_len=L(rdata). If L=1 →HOLD, no read. If L≥2: issue read fpc this cycle, fpc++, →RECV_OP1.
- RECV_OP1: latch ins_op1. If len=2 →HOLD; else issue read fpc, fpc++, →RECV_OP2.
- RECV_OP2: latch ins_op2, →HOLD.
- HOLD: ins_valid=1; all ins_* stable. On ins_ready=1: issue read fpc, fpc++, ins_pc<=fpc, →RECV_OPC (ins_valid 0 next cycle). Otherwise no read.
- Length L(op), cc=op[1:0], bbb=op[4:2]:
  - cc=01: bbb 011,110,111 →3; else →2.
  - cc=10: bbb 000,001,101 →2; 011,111 →3; 010,100,110 →1.
  - cc=00: bbb 001,100,101 →2; 011,111 →3; 010,110 →1; bbb 000: op 00 (BRK) →2, 20 (JSR) →3, 40/60 →1, 80/A0/C0/E0 →2.
  - cc=11 (unofficial) →1.
- Redirect (highest priority below rst, any state): fpc<=redir_pc, →ISSUE, ins_valid<=0, mem_ren=0 that cycle; read data arriving next cycle discarded. Simultaneous redir_en with ins_valid&ins_ready: handshake completes, redirect wins, no read issued.

## Timing

- Reset values: state ISSUE, fpc=RST_PC, ins_valid=0, ins_opcode/op1/op2=0, ins_len=0, ins_pc=0. mem_ren forced 0 while rst=1.
- Latency from ISSUE (cycle n): 1-byte valid at n+2, 2-byte n+3, 3-byte n+4.
- Steady-state with ins_ready=1: 1-byte every 2 cycles, 2-byte every 3, 3-byte every 4.
- At most one read outstanding; no read issued in HOLD unless ins_ready=1.
- rst mid-instruction: partial instruction discarded, restart at RST_PC.

## Test plan

- Reset, RST_PC=C000, mem C000..: A9 05 → cycle 0 addr C000, cycle 1 addr C001, cycle 3 ins_valid with opcode A9, op1 05, op2 00, len 2, pc C000.
- Stream EA EA EA, ins_ready=1 → ins_valid every 2nd cycle, ins_pc C000, C001, C002, len 1.
- 4C 34 12 with ins_ready=0 for 5 cycles → outputs constant, mem_ren=0 during hold; on ready, mem_addr=C003.
- redir_en with redir_pc=8000 during RECV_OP1 of AD → next cycle mem_addr=8000, no valid for the old instruction, next ins_pc=8000.
- AD at FFFE → reads FFFF, 0000; ins_pc FFFE, len 3; next fetch 0001.
- Length sweep: 00→2, 20→3, 40→1, 10→2, 6C→3, 8A→1, 96→2, BE→3, FF→1.
